sad_engine_pipe: RTL and testbench
==================================

// Module: sad_engine_pipe
// PURPOSE
//   Parametrised pipelined sum-of-absolute-differences engine for block-matching motion estimation.
//   Accepts one row of current-block and candidate-block pixels per cycle, accumulates per-candidate
//   SAD over ROWS rows, and tracks the minimum SAD and its candidate address across a search window.
//   Sits between the search-window shift register and the motion-vector writeback logic.
// PARAMETERS
//   PIX_W    8   bits per pixel (unsigned)
//   ROW_PIX  4   pixels per row; power of two, >=2
//   ROWS     4   rows per block (candidate SAD spans ROWS accepted rows)
//   ADDR_W   8   candidate address width (packed motion vector {dy,dx})
//   derived: L = clog2(ROW_PIX); SAD_W = PIX_W + clog2(ROW_PIX*ROWS)  (12 for defaults)
// PORTS
//   clk        in   1                clock, rising edge
//   rst_n      in   1                synchronous reset, active low
//   in_valid   in   1                row present on cur_row/can_row this cycle
//   in_sof     in   1                row is row 0 of a new candidate (qualified by in_valid)
//   cur_row    in   ROW_PIX*PIX_W    current-block row, pixel 0 in LSBs
//   can_row    in   ROW_PIX*PIX_W    candidate-block row, pixel 0 in LSBs
//   cand_addr  in   ADDR_W           candidate address, sampled on row 0 only
//   search_clr in   1                start new search: clear best tracker
//   sad_valid  out  1                one-cycle pulse: sad_out/sad_addr hold a completed SAD
//   sad_out    out  SAD_W            completed candidate SAD
//   sad_addr   out  ADDR_W           address of that candidate
//   res        out  SAD_W+ADDR_W     {sad_out, sad_addr}
//   best_valid out  1                at least one SAD seen since last search_clr/reset
//   best_sad   out  SAD_W            minimum SAD since last search_clr
//   best_addr  out  ADDR_W           address of minimum SAD
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): all pipeline valids, row index, accumulator, sad_valid, sad_out,
//     sad_addr, best_valid, best_addr -> 0; best_sad -> all ones. Applies mid-block; in-flight rows dropped.
//   - No backpressure; throughput one row per cycle; in_valid=0 inserts a bubble, state holds.
//   - Stage 1 (edge after accept): |cur-can| per pixel, PIX_W bits, unsigned compare-and-subtract.
//   - Stages 2..L+1: registered binary adder tree, width grows one bit per level; row sum at L+1.
//   - Sideband (valid, row index, last, addr) travels in a shift register matched to data latency.
//   - Row index: in_valid&in_sof -> 0; else in_valid -> idx+1, wraps ROWS-1 -> 0 (back-to-back
//     candidates need no sof). cand_addr captured when idx==0.
//   - in_sof while idx!=0: partial candidate abandoned, accumulator restarts, no sad_valid for it.
//   - Accumulate stage: row 0 loads acc=rowsum; rows 1..ROWS-2 add; row ROWS-1 registers
//     sad_out=acc+rowsum, sad_addr, sad_valid=1. Latency: last row accepted at cycle t ->
//     sad_valid at t+L+2. No overflow possible by SAD_W construction.
//   - Best tracker updates on the same edge as sad_valid, comparing new SAD against best_sad:
//     strictly less replaces (ties keep the earlier candidate); best_valid set to 1.
//   - search_clr: best_sad -> all ones, best_addr -> 0, best_valid -> 0, on the next edge; does not
//     disturb the SAD pipeline. If a SAD completes on the same edge, clear applies first and that SAD
//     becomes best (best_valid=1).
//   - sad_valid deasserts the cycle after its pulse unless another SAD completes (back-to-back: every
//     ROWS cycles).
// TESTING (defaults PIX_W=8, ROW_PIX=4, ROWS=4, L=2)
//   1 identical cur/can rows x4, addr 0x35 -> sad_valid at t+4 after last row, sad_out=0, res=0x00035.
//   2 cur all 0x00, can all 0xFF -> sad_out=4080 (0xFF0); swap cur/can -> 4080 (abs symmetry);
//     cur=10,can=3 everywhere -> 112.
//   3 search_clr, then candidates A=0x11 SAD 200, B=0x22 SAD 100, C=0x33 SAD 100 back-to-back ->
//     sad_valid every 4 cycles; final best_sad=100, best_addr=0x22, best_valid=1.
//   4 in_sof at row 2 of a candidate, then 4 rows SAD 64 -> exactly one sad_valid, sad_out=64.
//   5 search_clr on same edge as completing SAD 500 (prev best 10) -> best_sad=500, best_valid=1.
//   6 rst_n low for 1 cycle mid-block, then one full block -> no spurious sad_valid; outputs at reset
//     values; next block reports correct SAD; in_valid bubbles between rows do not change result.

Source files
------------

// File: rtl/sad_engine_pipe.sv
// Pipelined sum-of-absolute-differences engine for block-matching motion estimation.
// One row per cycle: abs-diff stage, registered adder tree, per-candidate accumulator, best-SAD tracker.
module sad_engine_pipe #(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 4,
    parameter int ROWS    = 4,
    parameter int ADDR_W  = 8,
    localparam int L      = $clog2(ROW_PIX),
    localparam int SAD_W  = PIX_W + $clog2(ROW_PIX * ROWS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [ROW_PIX*PIX_W-1:0]   cur_row,
    input  logic [ROW_PIX*PIX_W-1:0]   can_row,
    input  logic [ADDR_W-1:0]          cand_addr,
    input  logic                       search_clr,
    output logic                       sad_valid,
    output logic [SAD_W-1:0]           sad_out,
    output logic [ADDR_W-1:0]          sad_addr,
    output logic [SAD_W+ADDR_W-1:0]    res,
    output logic                       best_valid,
    output logic [SAD_W-1:0]           best_sad,
    output logic [ADDR_W-1:0]          best_addr
);

    localparam int TREE_W = PIX_W + L;
    localparam int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [IDX_W-1:0]  idx_cnt;
    logic [IDX_W-1:0]  idx_in;
    logic [ADDR_W-1:0] addr_hold;
    logic [ADDR_W-1:0] addr_in;

    // Row index of the incoming row; sof forces row 0 and abandons any partial candidate.
    always_comb begin
        idx_in  = in_sof ? '0 : idx_cnt;
        addr_in = (idx_in == '0) ? cand_addr : addr_hold;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_cnt <= '0;
        end else if (in_valid) begin
            idx_cnt <= (idx_in == LAST_IDX) ? '0 : idx_in + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && (idx_in == '0)) begin
            addr_hold <= cand_addr;
        end
    end

    logic [TREE_W-1:0] tree_p [0:L][0:ROW_PIX-1];
    logic [IDX_W-1:0]  idx_p  [0:L];
    logic [ADDR_W-1:0] addr_p [0:L];
    logic [L:0]        vld_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[L-1:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        // stage 0: per-pixel absolute differences
        if (in_valid) begin
            for (int j = 0; j < ROW_PIX; j++) begin
                tree_p[0][j] <= TREE_W'(abs_diff(cur_row[j*PIX_W +: PIX_W],
                                                 can_row[j*PIX_W +: PIX_W]));
            end
            idx_p[0]  <= idx_in;
            addr_p[0] <= addr_in;
        end
        // stages 1..L: adder tree, halving the entry count each level
        for (int s = 1; s <= L; s++) begin
            if (vld_p[s-1]) begin
                for (int j = 0; j < (ROW_PIX >> s); j++) begin
                    tree_p[s][j] <= tree_p[s-1][2*j] + tree_p[s-1][2*j+1];
                end
                idx_p[s]  <= idx_p[s-1];
                addr_p[s] <= addr_p[s-1];
            end
        end
    end

    logic [SAD_W-1:0] acc;
    logic [SAD_W-1:0] rowsum;
    logic [SAD_W-1:0] sad_new;
    logic             sad_done;

    always_comb begin
        rowsum   = SAD_W'(tree_p[L][0]);
        sad_new  = ((idx_p[L] == '0) ? '0 : acc) + rowsum;
        sad_done = vld_p[L] && (idx_p[L] == LAST_IDX);
    end

    // accumulate stage: row 0 reloads, the last row publishes the candidate SAD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            sad_valid <= 1'b0;
            sad_out   <= '0;
            sad_addr  <= '0;
        end else begin
            sad_valid <= sad_done;
            if (vld_p[L]) begin
                acc <= sad_new;
            end
            if (sad_done) begin
                sad_out  <= sad_new;
                sad_addr <= addr_p[L];
            end
        end
    end

    // A clear coinciding with a completing SAD lets that SAD seed the new search.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_valid <= 1'b0;
            best_sad   <= '1;
            best_addr  <= '0;
        end else if (search_clr) begin
            best_valid <= sad_done;
            best_sad   <= sad_done ? sad_new : '1;
            best_addr  <= sad_done ? addr_p[L] : '0;
        end else if (sad_done) begin
            best_valid <= 1'b1;
            if (sad_new < best_sad) begin
                best_sad  <= sad_new;
                best_addr <= addr_p[L];
            end
        end
    end

    assign res = {sad_out, sad_addr};

endmodule

// File: tb/tb_sad_engine_pipe.sv
// Directed-vector bench for sad_engine_pipe at default parameters (PIX_W=8, ROW_PIX=4, ROWS=4).
module tb_sad_engine_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [31:0] cur_row;
    logic [31:0] can_row;
    logic [7:0]  cand_addr;
    logic        search_clr;
    logic        sad_valid;
    logic [11:0] sad_out;
    logic [7:0]  sad_addr;
    logic [19:0] res;
    logic        best_valid;
    logic [11:0] best_sad;
    logic [7:0]  best_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    sad_engine_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .cur_row    (cur_row),
        .can_row    (can_row),
        .cand_addr  (cand_addr),
        .search_clr (search_clr),
        .sad_valid  (sad_valid),
        .sad_out    (sad_out),
        .sad_addr   (sad_addr),
        .res        (res),
        .best_valid (best_valid),
        .best_sad   (best_sad),
        .best_addr  (best_addr)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic sof, input logic [31:0] cur,
                        input logic [31:0] can, input logic [7:0] addr, input logic clr);
        in_valid   = v;
        in_sof     = sof;
        cur_row    = cur;
        can_row    = can;
        cand_addr  = addr;
        search_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b0);
    endtask

    // Four identical rows (sof on the first), then three idle cycles so the SAD pulse is visible.
    task automatic send_block(input logic [31:0] cur, input logic [31:0] can, input logic [7:0] addr);
        for (int r = 0; r < 4; r++) step(1'b1, r == 0, cur, can, (r == 0) ? addr : 8'hEE, 1'b0);
        for (int k = 0; k < 3; k++) idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        idle();
        n_cmp++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sad_valid: got %0d want 0", sad_valid); end
        n_cmp++; if (sad_out !== 12'd0) begin n_fail++; $display("FAIL reset_sad_out: got %0d want 0", sad_out); end
        n_cmp++; if (sad_addr !== 8'd0) begin n_fail++; $display("FAIL reset_sad_addr: got %0h want 0", sad_addr); end
        n_cmp++; if (res !== 20'd0) begin n_fail++; $display("FAIL reset_res: got %0h want 0", res); end
        n_cmp++; if (best_valid !== 1'b0) begin n_fail++; $display("FAIL reset_best_valid: got %0d want 0", best_valid); end
        n_cmp++; if (best_sad !== 12'hFFF) begin n_fail++; $display("FAIL reset_best_sad: got %0h want fff", best_sad); end
        n_cmp++; if (best_addr !== 8'd0) begin n_fail++; $display("FAIL reset_best_addr: got %0h want 0", best_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_identical();
        for (int r = 0; r < 4; r++)
            step(1'b1, r == 0, 32'h12345678, 32'h12345678, (r == 0) ? 8'h35 : 8'hAA, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            idle();
            n_cmp++;
            if (sad_valid !== (k == 3)) begin
                n_fail++; $display("FAIL ident_latency_t+%0d: sad_valid got %0d want %0d", k + 1, sad_valid, k == 3);
            end
        end
        n_cmp++; if (sad_out !== 12'd0) begin n_fail++; $display("FAIL ident_sad: got %0d want 0", sad_out); end
        n_cmp++; if (sad_addr !== 8'h35) begin n_fail++; $display("FAIL ident_addr: got %0h want 35", sad_addr); end
        n_cmp++; if (res !== 20'h00035) begin n_fail++; $display("FAIL ident_res: got %0h want 00035", res); end
        idle();
        n_cmp++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL ident_pulse_end: got %0d want 0", sad_valid); end
    endtask

    task automatic test_patterns();
        logic [31:0] cur_v [4] = '{32'h00000000, 32'hFFFFFFFF, 32'h0A0A0A0A, 32'h00FF10F0};
        logic [31:0] can_v [4] = '{32'hFFFFFFFF, 32'h00000000, 32'h03030303, 32'hFF0020E0};
        logic [11:0] exp_v [4] = '{12'd4080, 12'd4080, 12'd112, 12'd2168};
        for (int p = 0; p < 4; p++) begin
            send_block(cur_v[p], can_v[p], 8'(p + 1));
            n_cmp++; if (sad_valid !== 1'b1) begin n_fail++; $display("FAIL pat%0d_valid: got %0d want 1", p, sad_valid); end
            n_cmp++; if (sad_out !== exp_v[p]) begin n_fail++; $display("FAIL pat%0d_sad: got %0d want %0d", p, sad_out, exp_v[p]); end
            n_cmp++; if (sad_addr !== 8'(p + 1)) begin n_fail++; $display("FAIL pat%0d_addr: got %0h want %0h", p, sad_addr, p + 1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] can_v  [3] = '{32'h140A0A0A, 32'h0A050505, 32'h0A050505};
        logic [7:0]  addr_v [3] = '{8'h11, 8'h22, 8'h33};
        logic [11:0] sad_v  [3] = '{12'd200, 12'd100, 12'd100};
        logic [7:0]  baddr_v[3] = '{8'h11, 8'h22, 8'h22};
        step(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b1);
        n_cmp++; if (best_valid !== 1'b0) begin n_fail++; $display("FAIL clr_best_valid: got %0d want 0", best_valid); end
        n_cmp++; if (best_sad !== 12'hFFF) begin n_fail++; $display("FAIL clr_best_sad: got %0h want fff", best_sad); end
        n_cmp++; if (best_addr !== 8'h00) begin n_fail++; $display("FAIL clr_best_addr: got %0h want 0", best_addr); end
        for (int c = 0; c < 18; c++) begin
            int k;
            k = (c - 6) / 4;
            if (c < 12) step(1'b1, c == 0, 32'h0, can_v[c/4], (c % 4 == 0) ? addr_v[c/4] : 8'hEE, 1'b0);
            else idle();
            n_cmp++;
            if (sad_valid !== (c == 6 || c == 10 || c == 14)) begin
                n_fail++; $display("FAIL b2b_valid_c%0d: got %0d want %0d", c, sad_valid, c == 6 || c == 10 || c == 14);
            end
            if (c == 6 || c == 10 || c == 14) begin
                n_cmp++; if (sad_out !== sad_v[k]) begin n_fail++; $display("FAIL b2b_sad%0d: got %0d want %0d", k, sad_out, sad_v[k]); end
                n_cmp++; if (sad_addr !== addr_v[k]) begin n_fail++; $display("FAIL b2b_addr%0d: got %0h want %0h", k, sad_addr, addr_v[k]); end
                n_cmp++; if (best_sad !== sad_v[(k == 0) ? 0 : 1]) begin n_fail++; $display("FAIL b2b_best_sad%0d: got %0d want %0d", k, best_sad, sad_v[(k == 0) ? 0 : 1]); end
                n_cmp++; if (best_addr !== baddr_v[k]) begin n_fail++; $display("FAIL b2b_best_addr%0d: got %0h want %0h", k, best_addr, baddr_v[k]); end
            end
        end
        n_cmp++; if (best_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_best_valid: got %0d want 1", best_valid); end
    endtask

    task automatic test_sof_abandon();
        int pulses = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 2) step(1'b1, c == 0, 32'h0, 32'hFFFFFFFF, 8'h44, 1'b0);
            else if (c < 6) step(1'b1, c == 2, 32'h04040404, 32'h0, (c == 2) ? 8'h55 : 8'hEE, 1'b0);
            else idle();
            if (sad_valid === 1'b1) pulses++;
            n_cmp++;
            if (sad_valid !== (c == 8)) begin
                n_fail++; $display("FAIL sof_valid_c%0d: got %0d want %0d", c, sad_valid, c == 8);
            end
            if (c == 8) begin
                n_cmp++; if (sad_out !== 12'd64) begin n_fail++; $display("FAIL sof_sad: got %0d want 64", sad_out); end
                n_cmp++; if (sad_addr !== 8'h55) begin n_fail++; $display("FAIL sof_addr: got %0h want 55", sad_addr); end
            end
        end
        n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL sof_pulse_count: got %0d want 1", pulses); end
    endtask

    task automatic test_clr_collision();
        logic [31:0] small_v [4] = '{32'h3, 32'h3, 32'h2, 32'h2};
        step(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b1);
        for (int r = 0; r < 4; r++) step(1'b1, r == 0, 32'h0, small_v[r], (r == 0) ? 8'h5A : 8'hEE, 1'b0);
        for (int k = 0; k < 3; k++) idle();
        n_cmp++; if (sad_out !== 12'd10) begin n_fail++; $display("FAIL coll_prev_sad: got %0d want 10", sad_out); end
        n_cmp++; if (best_sad !== 12'd10) begin n_fail++; $display("FAIL coll_prev_best: got %0d want 10", best_sad); end
        n_cmp++; if (best_addr !== 8'h5A) begin n_fail++; $display("FAIL coll_prev_addr: got %0h want 5a", best_addr); end
        for (int r = 0; r < 4; r++) step(1'b1, r == 0, 32'h0, 32'h0000007D, (r == 0) ? 8'hA5 : 8'hEE, 1'b0);
        idle();
        idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b1);
        n_cmp++; if (sad_valid !== 1'b1) begin n_fail++; $display("FAIL coll_valid: got %0d want 1", sad_valid); end
        n_cmp++; if (sad_out !== 12'd500) begin n_fail++; $display("FAIL coll_sad: got %0d want 500", sad_out); end
        n_cmp++; if (best_sad !== 12'd500) begin n_fail++; $display("FAIL coll_best_sad: got %0d want 500", best_sad); end
        n_cmp++; if (best_addr !== 8'hA5) begin n_fail++; $display("FAIL coll_best_addr: got %0h want a5", best_addr); end
        n_cmp++; if (best_valid !== 1'b1) begin n_fail++; $display("FAIL coll_best_valid: got %0d want 1", best_valid); end
        idle();
    endtask

    task automatic test_mid_reset();
        for (int r = 0; r < 2; r++) step(1'b1, r == 0, 32'h0, 32'hFFFFFFFF, 8'h66, 1'b0);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        n_cmp++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %0d want 0", sad_valid); end
        n_cmp++; if (sad_out !== 12'd0) begin n_fail++; $display("FAIL mrst_sad: got %0d want 0", sad_out); end
        n_cmp++; if (sad_addr !== 8'd0) begin n_fail++; $display("FAIL mrst_addr: got %0h want 0", sad_addr); end
        n_cmp++; if (best_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_best_valid: got %0d want 0", best_valid); end
        n_cmp++; if (best_sad !== 12'hFFF) begin n_fail++; $display("FAIL mrst_best_sad: got %0h want fff", best_sad); end
        n_cmp++; if (best_addr !== 8'd0) begin n_fail++; $display("FAIL mrst_best_addr: got %0h want 0", best_addr); end
        for (int c = 0; c < 14; c++) begin
            if (c == 0 || c == 2 || c == 3 || c == 5)
                step(1'b1, 1'b0, 32'h01020304, 32'h04030201, (c == 0) ? 8'h77 : 8'h99, 1'b0);
            else idle();
            n_cmp++;
            if (sad_valid !== (c == 8)) begin
                n_fail++; $display("FAIL mrst_bubble_valid_c%0d: got %0d want %0d", c, sad_valid, c == 8);
            end
            if (c == 8) begin
                n_cmp++; if (sad_out !== 12'd32) begin n_fail++; $display("FAIL mrst_bubble_sad: got %0d want 32", sad_out); end
                n_cmp++; if (sad_addr !== 8'h77) begin n_fail++; $display("FAIL mrst_bubble_addr: got %0h want 77", sad_addr); end
                n_cmp++; if (best_sad !== 12'd32) begin n_fail++; $display("FAIL mrst_bubble_best: got %0d want 32", best_sad); end
                n_cmp++; if (best_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_bubble_best_valid: got %0d want 1", best_valid); end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        cur_row    = '0;
        can_row    = '0;
        cand_addr  = '0;
        search_clr = 1'b0;
        test_reset();
        test_identical();
        test_patterns();
        test_back_to_back();
        test_sof_abandon();
        test_clr_collision();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
